// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_pkg
// Description : Shared widths, ALU opcode encoding and the write-back entry
//               type for the 24-bit ALU and its write-back stage.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int DATA_W = 24;
  localparam int DEST_W = 4;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_MUL = 4'd3,
    OP_DIV = 4'd4,
    OP_INC = 4'd5,
    OP_DEC = 4'd6,
    OP_NEG = 4'd7,
    OP_NOT = 4'd8,
    OP_AND = 4'd9,
    OP_OR  = 4'd10,
    OP_XOR = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DEST_W-1:0] dest;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/alu_writeback_stage_if.sv
`default_nettype none
// ============================================================================
// Interface   : alu_writeback_stage_if
// Description : ALU-result input handshake and register-file write handshake
//               of the write-back stage. slave = stage view, master = env view.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_writeback_stage_if #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int DEST_W = alu_pkg::DEST_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_z;
  logic              in_n;
  logic              in_flag_we;
  logic [DEST_W-1:0] in_dest;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [DEST_W-1:0] out_dest;

  modport slave (
    input  in_valid, in_result, in_z, in_n, in_flag_we, in_dest, out_ready,
    output in_ready, out_valid, out_data, out_dest
  );

  modport master (
    output in_valid, in_result, in_z, in_n, in_flag_we, in_dest, out_ready,
    input  in_ready, out_valid, out_data, out_dest
  );

endinterface
`default_nettype wire

// File: rtl/alu_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_wb_fifo
// Description : Power-of-two FIFO with occupancy count and synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_wb_fifo #(
  parameter  int W     = 28,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone qualifies its contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/alu_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_writeback_stage
// Description : Accepts ALU results, commits Z/N flags at acceptance and
//               buffers writes toward the register file. Optional macro
//               ALU_WB_BYPASS_EN adds an empty-buffer combinational bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_writeback_stage #(
  parameter  int DATA_W = alu_pkg::DATA_W,
  parameter  int DEST_W = alu_pkg::DEST_W,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  alu_writeback_stage_if.slave  bus,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic [CNT_W-1:0]      count
);
  import alu_pkg::*;

  localparam int ENTRY_W = DATA_W + DEST_W;

  logic               rdy_en_q, rdy_en_d;
  logic               flag_z_q, flag_z_d;
  logic               flag_n_q, flag_n_d;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_empty;
  logic               accept;
  logic               bypass;
  logic               push;
  logic               pop;

  // rdy_en_q holds in_ready low through reset and the first cycle after it.
  assign fifo_empty   = (fifo_count == '0);
  assign bus.in_ready = rdy_en_q && (fifo_count != CNT_W'(DEPTH)) && !flush;
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef ALU_WB_BYPASS_EN
  assign bypass       = fifo_empty && accept && bus.out_ready;
  assign bus.out_data = bypass ? bus.in_result : fifo_rdata[ENTRY_W-1:DEST_W];
  assign bus.out_dest = bypass ? bus.in_dest   : fifo_rdata[DEST_W-1:0];
`else
  assign bypass       = 1'b0;
  assign bus.out_data = fifo_rdata[ENTRY_W-1:DEST_W];
  assign bus.out_dest = fifo_rdata[DEST_W-1:0];
`endif

  assign bus.out_valid = !fifo_empty || bypass;
  assign push          = accept && !bypass;
  assign pop           = bus.out_ready && !fifo_empty;

  alu_wb_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.in_result, bus.in_dest}),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  always_comb begin
    rdy_en_d = 1'b1;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    if (accept && bus.in_flag_we) begin
      flag_z_d = bus.in_z;
      flag_n_d = bus.in_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      rdy_en_q <= rdy_en_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
  assign count  = fifo_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_writeback_stage
// Description : Directed self-checking bench with a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_writeback_stage;
  import alu_pkg::*;

  localparam int DW    = 24;
  localparam int AW    = 4;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          flag_z;
  logic          flag_n;
  logic [CW-1:0] count;

  alu_writeback_stage_if #(.DATA_W(DW), .DEST_W(AW)) bus ();

  alu_writeback_stage #(
    .DATA_W (DW),
    .DEST_W (AW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .bus    (bus),
    .flag_z (flag_z),
    .flag_n (flag_n),
    .count  (count)
  );

  always #5 clk = ~clk;

  int        n_cmp = 0;
  int        n_err = 0;
  wb_entry_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [AW-1:0] a,
                       input logic z, input logic n, input logic we);
    bus.in_valid   = v;
    bus.in_result  = d;
    bus.in_dest    = a;
    bus.in_z       = z;
    bus.in_n       = n;
    bus.in_flag_we = we;
  endtask

  // Scoreboard: accepted inputs are queued, completed writes are checked in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) begin
        wb_entry_t e;
        e.data = bus.in_result;
        e.dest = bus.in_dest;
        sb.push_back(e);
      end
      if (bus.out_valid && bus.out_ready) begin
        check("write_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          wb_entry_t x;
          x = sb.pop_front();
          check("wr_data", 32'(bus.out_data), 32'(x.data));
          check("wr_dest", 32'(bus.out_dest), 32'(x.dest));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    #2;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_flag_z", 32'(flag_z), 32'd0);
    check("rst_flag_n", 32'(flag_n), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    mid();
    check("ready_before_edge", 32'(bus.in_ready), 32'd0);
    tick();
    mid();
    check("ready_after_edge", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of traffic
    tick();
    drive(1'b1, 24'h000005, 4'd3, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    mid();
    check("mid_count", 32'(count), 32'd1);
    check("mid_out_valid", 32'(bus.out_valid), 32'd1);
    check("mid_flag_z", 32'(flag_z), 32'd1);
    check("mid_flag_n", 32'(flag_n), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_flag_z", 32'(flag_z), 32'd0);
    check("arst_flag_n", 32'(flag_n), 32'd0);
    sb.delete();
    bus.out_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    mid();
    check("post_rst_count", 32'(count), 32'd0);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    // Fill and stall
    tick();
    bus.out_ready = 1'b0;
    drive(1'b1, 24'h123456, 4'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 24'hFFFFFF, 4'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 24'hAAAAAA, 4'd3, 1'b0, 1'b0, 1'b0);
    mid();
    check("full_count", 32'(count), 32'd2);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    mid();
    check("refused_count", 32'(count), 32'd2);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    mid();
    check("drained_count", 32'(count), 32'd0);
    check("drained_sb", 32'(sb.size()), 32'd0);

    // Concurrent push and pop at count 1
    tick();
    bus.out_ready = 1'b0;
    drive(1'b1, 24'h000100, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.out_ready = 1'b1;
    drive(1'b1, 24'h000101, 4'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i < 10; i++) begin
      mid();
      check("pp_count", 32'(count), 32'd1);
      tick();
      drive(1'b1, 24'h000100 + 24'(i), 4'(i), 1'b0, 1'b0, 1'b0);
    end
    mid();
    check("pp_count", 32'(count), 32'd1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    mid();
    check("pp_tail_count", 32'(count), 32'd1);
    tick();
    mid();
    check("pp_empty_count", 32'(count), 32'd0);

    // Flag commit
    tick();
    drive(1'b1, 24'h000000, 4'd5, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 24'h800000, 4'd6, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    mid();
    check("flag_hold_z", 32'(flag_z), 32'd1);
    check("flag_hold_n", 32'(flag_n), 32'd0);
    tick();
    drive(1'b1, 24'h800000, 4'd6, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    mid();
    check("flag_upd_z", 32'(flag_z), 32'd0);
    check("flag_upd_n", 32'(flag_n), 32'd1);

    // Flush with a full buffer and a concurrent input
    tick();
    bus.out_ready = 1'b0;
    drive(1'b1, 24'h111111, 4'd8, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 24'h222222, 4'd9, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 24'h777777, 4'd10, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    mid();
    check("pre_flush_count", 32'(count), 32'd2);
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    sb.delete();
    mid();
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_flag_z", 32'(flag_z), 32'd1);
    check("flush_flag_n", 32'(flag_n), 32'd1);
    check("post_flush_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    mid();
    check("post_flush_count", 32'(count), 32'd0);

    // Minimum latency from an empty buffer
    tick();
    drive(1'b1, 24'h00ABCD, 4'd7, 1'b0, 1'b0, 1'b0);
    mid();
`ifdef ALU_WB_BYPASS_EN
    check("byp_out_valid", 32'(bus.out_valid), 32'd1);
    check("byp_out_data", 32'(bus.out_data), 32'h00ABCD);
    check("byp_out_dest", 32'(bus.out_dest), 32'd7);
    check("byp_count", 32'(count), 32'd0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    mid();
    check("byp_after_count", 32'(count), 32'd0);
    check("byp_after_valid", 32'(bus.out_valid), 32'd0);
`else
    check("lat_same_cycle_valid", 32'(bus.out_valid), 32'd0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    mid();
    check("lat_out_valid", 32'(bus.out_valid), 32'd1);
    check("lat_out_data", 32'(bus.out_data), 32'h00ABCD);
    check("lat_out_dest", 32'(bus.out_dest), 32'd7);
    check("lat_count", 32'(count), 32'd1);
    tick();
    mid();
    check("lat_after_valid", 32'(bus.out_valid), 32'd0);
    check("lat_after_count", 32'(count), 32'd0);
`endif

    tick();
    mid();
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
